// File: rtl/aes_pkg.sv
// Shared AES constants and helpers, used by the block packer and the encryptor
// wrappers.
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_BYTES   = 16;

   // Number of input beats that make up one AES block.
   function automatic int beats_for(input int in_w);
      return AES_BLOCK_W / in_w;
   endfunction

endpackage

// File: rtl/aes_block_packer.sv
// Packs a narrow valid/ready plaintext stream into 128-bit AES blocks.
// The first beat lands in the MSBs. The output is a registered holding stage.
module aes_block_packer
   import aes_pkg::*;
#(
   parameter int  BLOCK_W = AES_BLOCK_W,
   parameter int  IN_W    = 8,
   localparam int BEATS   = beats_for(IN_W),
   localparam int CNT_W   = $clog2(BEATS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic [IN_W-1:0]    in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [BLOCK_W-1:0] out_block,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CNT_W-1:0]   beat_cnt
);

   // The accumulator holds only the BEATS-1 beats that are already taken.
   // The final beat bypasses it and goes straight into out_block.
   localparam int ACC_W = BLOCK_W - IN_W;

   logic [ACC_W-1:0]   acc;
   logic [BLOCK_W-1:0] shifted;
   logic               last_beat;
   logic               accept;
   logic               drain;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      last_beat = 1'b0;
      accept    = 1'b0;
      drain     = 1'b0;
      in_ready  = 1'b0;
      shifted   = {acc, in_data};

      last_beat = (beat_cnt == CNT_W'(BEATS - 1));
      // Only the final beat has to wait for a free holding register.
      in_ready  = !rst && !clr && !(last_beat && out_valid && !out_ready);
      accept    = in_valid && in_ready;
      drain     = out_valid && out_ready;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together on the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         beat_cnt  <= '0;
         out_block <= '0;
         out_valid <= 1'b0;
      end else begin
         if (drain) begin
            out_valid <= 1'b0;
         end

         if (clr) begin
            acc      <= '0;
            beat_cnt <= '0;
         end else if (accept) begin
            if (last_beat) begin
               // This assignment comes after the drain above, so a drain and a
               // final beat in the same cycle keep out_valid high with no bubble.
               out_block <= shifted;
               out_valid <= 1'b1;
               acc       <= '0;
               beat_cnt  <= '0;
            end else begin
               acc      <= shifted[ACC_W-1:0];
               beat_cnt <= beat_cnt + CNT_W'(1);
            end
         end
      end
   end

   a_cnt_range : assert property (@(posedge clk) disable iff (rst)
      int'(beat_cnt) < BEATS);

   a_hold_stable : assert property (@(posedge clk) disable iff (rst)
      (!rst && out_valid && !out_ready) |=> (out_valid && $stable(out_block)));

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer. It uses a byte-wide instance for the
// main scenarios and a 32-bit-wide instance for the word path.
module tb_aes_block_packer;

   logic         clk = 1'b0;
   logic         rst;
   logic         clr;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] out_block;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   beat_cnt;

   logic [31:0]  w_data;
   logic         w_valid;
   logic         w_ready;
   logic [127:0] w_block;
   logic         w_out_valid;
   logic         w_out_ready;
   logic [1:0]   w_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   logic [127:0] exp_q[$];

   always #5 clk = ~clk;

   aes_block_packer #(.IN_W(8)) u_dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_block(out_block), .out_valid(out_valid), .out_ready(out_ready),
      .beat_cnt(beat_cnt)
   );

   aes_block_packer #(.IN_W(32)) u_dut32 (
      .clk(clk), .rst(rst), .clr(1'b0),
      .in_data(w_data), .in_valid(w_valid), .in_ready(w_ready),
      .out_block(w_block), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .beat_cnt(w_cnt)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected block whose bytes count up from start.
   function automatic logic [127:0] seq_block(input logic [7:0] start);
      logic [127:0] b;
      b = '0;
      for (int i = 0; i < 16; i++) b = {b[119:0], 8'(start + 8'(i))};
      return b;
   endfunction

   // Monitor: every output handshake pops and compares one expected block.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_block: got %h, expected none", out_block);
         end else begin
            check("scoreboard_block", out_block, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input logic [7:0] d);
      bit got;
      got = 1'b0;
      in_data  = d;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("accept_timeout", 0, 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic push_seq(input logic [7:0] start, input int n);
      for (int i = 0; i < n; i++) push_beat(8'(start + 8'(i)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; clr = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
      w_data = '0; w_valid = 1'b0; w_out_ready = 1'b1;
      @(negedge clk);
      check("ready_low_in_reset", in_ready, 0);
      step();
      step();
      rst = 1'b0;
      check("reset_out_valid", out_valid, 0);
      check("reset_beat_cnt", beat_cnt, 0);
      check("reset_out_block", out_block, 0);

      // Single block: bytes 00,11,..,FF.
      exp_q.push_back(128'h00112233445566778899AABBCCDDEEFF);
      for (int i = 0; i < 16; i++) push_beat(8'(i * 17));
      check("single_valid_after_last", out_valid, 1);
      check("single_cnt_zero", beat_cnt, 0);
      check("single_block", out_block, 128'h00112233445566778899AABBCCDDEEFF);
      step();
      check("single_valid_one_cycle", out_valid, 0);

      // Back-to-back: 3 blocks, in_valid held high.
      for (int k = 0; k < 3; k++) exp_q.push_back(seq_block(8'(k * 16)));
      for (int e = 0; e < 48; e++) begin
         in_data  = 8'(e);
         in_valid = 1'b1;
         @(negedge clk);
         check($sformatf("b2b_ready_%0d", e), in_ready, 1);
         step();
         check($sformatf("b2b_valid_%0d", e), out_valid, (e % 16) == 15);
      end
      in_valid = 1'b0;
      step();

      // Backpressure: block A held, block B's final beat stalls.
      out_ready = 1'b0;
      exp_q.push_back(seq_block(8'h30));
      exp_q.push_back(seq_block(8'h40));
      push_seq(8'h30, 16);
      check("bp_a_valid", out_valid, 1);
      for (int i = 0; i < 15; i++) begin
         in_data  = 8'(8'h40 + 8'(i));
         in_valid = 1'b1;
         @(negedge clk);
         check($sformatf("bp_ready_beat_%0d", i + 1), in_ready, 1);
         step();
      end
      in_data = 8'h4F;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("bp_final_stalled", in_ready, 0);
         check("bp_cnt_15", beat_cnt, 15);
         check("bp_a_stable", out_block, seq_block(8'h30));
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_on_drain", in_ready, 1);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("bp_no_bubble", out_valid, 1);
      check("bp_b_loaded", out_block, seq_block(8'h40));
      check("bp_cnt_wrap", beat_cnt, 0);
      out_ready = 1'b1;
      step();
      check("bp_b_drained", out_valid, 0);

      // clr mid-block.
      push_seq(8'hA0, 5);
      check("clr_cnt_before", beat_cnt, 5);
      in_data = 8'hA5; in_valid = 1'b1; clr = 1'b1;
      @(negedge clk);
      check("clr_ready_low", in_ready, 0);
      step();
      clr = 1'b0; in_valid = 1'b0;
      check("clr_cnt_zero", beat_cnt, 0);
      out_ready = 1'b0;
      exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
      push_seq(8'h00, 16);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_keeps_valid", out_valid, 1);
      check("clr_keeps_block", out_block, 128'h000102030405060708090A0B0C0D0E0F);
      out_ready = 1'b1;
      step();
      check("clr_block_drained", out_valid, 0);

      // Reset with a pending block and 7 beats held.
      out_ready = 1'b0;
      exp_q.push_back(seq_block(8'h50));
      push_seq(8'h50, 16);
      push_seq(8'h60, 7);
      check("rst_pre_cnt", beat_cnt, 7);
      check("rst_pre_valid", out_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready_low", in_ready, 0);
      step();
      rst = 1'b0;
      void'(exp_q.pop_back());
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_cnt", beat_cnt, 0);
      check("rst_mid_block", out_block, 0);
      out_ready = 1'b1;
      exp_q.push_back(seq_block(8'h70));
      push_seq(8'h70, 16);
      step();

      // 32-bit beats.
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: w_data = 32'h00112233;
            1: w_data = 32'h44556677;
            2: w_data = 32'h8899AABB;
            default: w_data = 32'hCCDDEEFF;
         endcase
         w_valid = 1'b1;
         @(negedge clk);
         check($sformatf("w32_ready_%0d", i), w_ready, 1);
         step();
         if (i == 1) check("w32_cnt_2", w_cnt, 2);
      end
      w_valid = 1'b0;
      check("w32_valid", w_out_valid, 1);
      check("w32_block", w_block, 128'h00112233445566778899AABBCCDDEEFF);
      check("w32_cnt_wrap", w_cnt, 0);
      step();
      check("w32_drained", w_out_valid, 0);

      check("scoreboard_empty", 128'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
